// File: rtl/seg_pkg.sv
// Glyph table and segment bit positions shared by the display scanner.
// Latency: none (constants and a pure combinational lookup).
// Backpressure: not applicable.
package seg_pkg;

    // Segment bit positions inside the {a,b,c,d,e,f,g,dp} byte.
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-high glyphs; dp bit is always clear here and merged later.
    localparam logic [7:0] GLYPH_0     = 8'hFC;
    localparam logic [7:0] GLYPH_1     = 8'h60;
    localparam logic [7:0] GLYPH_2     = 8'hDA;
    localparam logic [7:0] GLYPH_3     = 8'hF2;
    localparam logic [7:0] GLYPH_4     = 8'h66;
    localparam logic [7:0] GLYPH_5     = 8'hB6;
    localparam logic [7:0] GLYPH_6     = 8'hBE;
    localparam logic [7:0] GLYPH_7     = 8'hE0;
    localparam logic [7:0] GLYPH_8     = 8'hFE;
    localparam logic [7:0] GLYPH_9     = 8'hF6;
    localparam logic [7:0] GLYPH_A     = 8'hEE;
    localparam logic [7:0] GLYPH_B     = 8'h3E;
    localparam logic [7:0] GLYPH_C     = 8'h9C;
    localparam logic [7:0] GLYPH_D     = 8'h7A;
    localparam logic [7:0] GLYPH_E     = 8'h9E;
    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            default: seg = GLYPH_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Control and pin bundle between the value source and the display scanner.
// Latency: none (wires only).
// Backpressure: none; load is a fire-and-forget strobe.
interface seg_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic                    enable;
    logic [7:0]              c_out;
    logic [NUM_DIGITS-1:0]   a_out;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output value_in, dp_in, load, blank_lz, enable,
        input  c_out, a_out, digit_idx
    );

    modport slave (
        input  value_in, dp_in, load, blank_lz, enable,
        output c_out, a_out, digit_idx
    );

endinterface

// File: rtl/seg_slot_timer.sv
// Slot divider plus digit index counter for the multiplexed display.
// Latency: tick is combinational from the count; digit_idx moves on the tick edge.
// Backpressure: free-running, never stalls.
module seg_slot_timer #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic             tick,
    output logic [IDX_W-1:0] digit_idx,
    output logic [IDX_W-1:0] idx_next
);
    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick     = (cnt_q == CNT_MAX);
    assign idx_next = (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);

    // Count clocks within a slot; step the digit index at the end of each slot.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q     <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            cnt_q     <= '0;
            digit_idx <= idx_next;
        end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment driver: shadowed hex value, lz blanking, enable, polarity.
// Latency: glyph registered one cycle after each slot tick; enable acts next cycle.
// Backpressure: none; load is always accepted, shown from the next output update.
module seg_display_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 1000,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input logic                clk_in,
    input logic                reset,
    seg_display_scanner_if.slave bus
);
    import seg_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // XOR masks: an all-zero active-high pattern maps to the "off" pin level.
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic                    tick;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_next;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    run_zero;
    logic [IDX_W-1:0]        sel_idx;
    logic [7:0]              seg_hi;
    logic [NUM_DIGITS-1:0]   an_hi;
    logic [7:0]              c_q;
    logic [NUM_DIGITS-1:0]   a_q;
    logic                    armed;
    logic                    lit;

    seg_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk_in   (clk_in),
        .reset    (reset),
        .tick     (tick),
        .digit_idx(idx_q),
        .idx_next (idx_next)
    );

    // Shadow registers decouple the source bus from the scan so glyphs never tear mid-slot.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (bus.load) begin
            shadow_val <= bus.value_in;
            shadow_dp  <= bus.dp_in;
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        run_zero  = 1'b1;
        blank_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_zero     = run_zero && (shadow_val[4*k +: 4] == 4'h0);
            blank_vec[k] = bus.blank_lz && (k != 0) && run_zero;
        end
    end

    // Build the active-high glyph and anode pattern for the digit about to be driven.
    always_comb begin
        sel_idx = tick ? idx_next : idx_q;
        seg_hi  = blank_vec[sel_idx] ? GLYPH_BLANK : hex_to_seg(shadow_val[4*int'(sel_idx) +: 4]);
        seg_hi[SEG_DP] = shadow_dp[sel_idx];
        an_hi          = '0;
        an_hi[sel_idx] = 1'b1;
    end

    // Output register: dark on disable, refresh on tick, or immediately re-light once armed.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            c_q   <= SEG_OFF;
            a_q   <= AN_OFF;
            armed <= 1'b0;
            lit   <= 1'b0;
        end else begin
            if (!bus.enable) begin
                c_q <= SEG_OFF;
                a_q <= AN_OFF;
                lit <= 1'b0;
            end else if (tick || (armed && !lit)) begin
                c_q <= seg_hi ^ SEG_OFF;
                a_q <= an_hi ^ AN_OFF;
                lit <= 1'b1;
            end
            if (tick) begin
                armed <= 1'b1;
            end
        end
    end

    assign bus.c_out     = c_q;
    assign bus.a_out     = a_q;
    assign bus.digit_idx = idx_q;

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Parametrised multiplexed seven-segment display driver for the board's common-anode display bank. It scans NUM_DIGITS hex digits in time-multiplexed order and latches a new display value through a load strobe. It adds per-digit decimal points, leading-zero blanking, an enable gate and selectable output polarity. It sits between the control unit (or a debug register) and the ca..cg/dp cathode and aa..ad anode pins, and it replaces the single-digit encoder plus its own divider.

Parameters:
NUM_DIGITS, 4, number of scanned digits (>=1).
REFRESH_DIV, 1000, clk_in cycles per digit slot (>=2). The default gives a 1 kHz slot rate and a 250 Hz frame from the 1 MHz clock.
SEG_ACTIVE_LOW, 1, 1 = cathode outputs driven low to light a segment.
ANODE_ACTIVE_LOW, 1, 1 = anode outputs driven low to select a digit.

Ports:
clk_in  in  1  system clock (1 MHz domain).
reset  in  1  synchronous, active-high reset.
value_in  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, and digit 0 is the least significant.
dp_in  in  NUM_DIGITS  decimal-point request per digit.
load  in  1  one-cycle strobe that latches value_in and dp_in into the shadow registers.
blank_lz  in  1  1 = blank leading zeros.
enable  in  1  0 = whole display dark.
c_out  out  8  {a,b,c,d,e,f,g,dp}: c_out[7] = segment a, c_out[0] = dp.
a_out  out  NUM_DIGITS  digit selects; a_out[k] selects digit k.
digit_idx  out  max(1,$clog2(NUM_DIGITS))  index of the digit currently driven.

Behaviour:
- Reset is synchronous and active-high. It applies on any cycle, including mid-slot, and every register takes its reset value on the next edge:
  - slot counter = 0, digit_idx = 0.
  - shadow value = 0, shadow dp = 0.
  - c_out = all segments off (8'hFF when SEG_ACTIVE_LOW).
  - a_out = all digits off (all ones when ANODE_ACTIVE_LOW).
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted when the count equals REFRESH_DIV-1.
  - On tick, digit_idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Output timing:
  - c_out and a_out are registered and computed from the digit_idx value that is current after the tick. Latency is 1 cycle from tick.
  - Exactly one a_out bit is active while enable=1. No bit is active while enable=0.
  - In the first slot after reset, outputs stay off until the first tick. The first tick selects digit 1.
- Load:
  - On load, the shadow registers capture value_in and dp_in.
  - Displayed data changes only at the next output register update, so no mid-slot glyph change occurs.
  - Load and tick in the same cycle: the output register uses the OLD shadow, and the new value appears from the following slot.
- Glyph encoding (active-high form, inverted when SEG_ACTIVE_LOW): 0..F are the standard hex glyphs (b,d lower case). Examples with dp off, active-low:
  - 0 = 8'h03.
  - 1 = 8'h9F.
  - 8 = 8'h01.
  - A = 8'h11.
  - F = 8'h71.
- Leading-zero blanking: digit k (k>0) is blanked when blank_lz=1 and nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit shows no segments, but its dp still follows the shadow dp.
  - The anode is still driven for a blanked digit, which keeps the duty cycle uniform.
- enable:
  - enable=0 forces c_out and a_out to off at the next register update, and this does not wait for a tick.
  - The counter and digit_idx keep running.
  - enable returning to 1 restores outputs at the next cycle for the current digit.
- Polarity parameters invert only the final output drivers. Internal logic is active-high.
- NUM_DIGITS=1: digit_idx stays 0, and tick only refreshes the output register.

Decomposition:
- Package seg_pkg holds:
  - the active-high glyph constants GLYPH_0..GLYPH_F and GLYPH_BLANK;
  - the segment bit-position constants SEG_A..SEG_DP;
  - the function hex_to_seg(nibble).
- One sub-module, seg_slot_timer: the REFRESH_DIV slot counter plus the digit_idx wrap counter. It outputs tick and digit_idx.
- Top level holds the shadow registers, the blanking logic and the output registers.

Test Plan:
Bench uses NUM_DIGITS=4, REFRESH_DIV=4 unless stated otherwise.
1. Reset, then idle for 20 cycles: c_out=8'hFF and a_out=4'hF until the first tick. After that, a_out cycles 4'hD, 4'hB, 4'h7, 4'hE every 4 cycles, with digit_idx matching.
2. load with value_in=16'h10A8, dp_in=4'b0100:
   - digit 0 shows 8'h01 (8);
   - digit 1 shows 8'h11 (A);
   - digit 2 shows 8'h02 (0 with dp lit);
   - digit 3 shows 8'h9F (1).
3. blank_lz=1, load value_in=16'h0005, dp_in=0: digits 3..1 show 8'hFF with their anodes still active, and digit 0 shows 5 (8'h49). Then value_in=16'h0000: digit 0 shows 8'h03.
4. load asserted on the tick cycle with a new value: the slot that starts on that tick shows the old nibble, and the following slot shows the new nibble.
5. enable=0 mid-slot: the next cycle has a_out=4'hF and c_out=8'hFF while digit_idx keeps advancing. enable=1 restores the correct glyph for the current digit_idx one cycle later.
6. reset pulsed mid-slot at digit_idx=2: the next cycle has digit_idx=0, outputs off, and shadow cleared. Repeat with SEG_ACTIVE_LOW=0 and ANODE_ACTIVE_LOW=0 to check that outputs are bitwise inverted (digit 0 showing "0" gives c_out=8'hFC).
